// File: rtl/mac_spike_scheduler.sv
// Sequences a single MAC unit (set, fixed-length timesteps ending in a clear pulse)
// and round-robin shares its source_address input among NUM_REQ spike requesters.
module mac_spike_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 12,
    parameter int TIMESTEP_CYCLES = 4,
    parameter int INIT_CYCLES     = 2,
    parameter int CNT_W           = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic                      stop,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      mac_set,
    output logic                      mac_clear,
    output logic [ADDR_W-1:0]         mac_src_addr,
    output logic                      mac_src_valid,
    output logic [CNT_W-1:0]          timestep_count,
    output logic [CNT_W-1:0]          last_spike_count,
    output logic                      busy
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CYC_MAX = (INIT_CYCLES > TIMESTEP_CYCLES) ? INIT_CYCLES : TIMESTEP_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc_cnt, cyc_cnt_nxt;
    logic               stop_pending, stop_pending_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   spike_cnt;

    logic [NUM_REQ-1:0] req_elig;
    logic [PTR_W:0]     cand;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ADDR_W-1:0]  win_addr;

    // Sequencer: INIT holds for INIT_CYCLES, RUN for TIMESTEP_CYCLES-1, CLEAR for one cycle.
    always_comb begin
        state_nxt        = state;
        cyc_cnt_nxt      = cyc_cnt;
        stop_pending_nxt = stop_pending;
        if (stop && (state != IDLE)) begin
            stop_pending_nxt = 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = INIT;
                    cyc_cnt_nxt = '0;
                end
            end
            INIT: begin
                if (cyc_cnt == CYC_W'(INIT_CYCLES - 1)) begin
                    state_nxt   = RUN;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            RUN: begin
                if (cyc_cnt == CYC_W'(TIMESTEP_CYCLES - 2)) begin
                    state_nxt   = CLEAR;
                    cyc_cnt_nxt = '0;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            CLEAR: begin
                cyc_cnt_nxt = '0;
                if (stop_pending) begin
                    state_nxt        = IDLE;
                    stop_pending_nxt = 1'b0;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cyc_cnt_nxt = '0;
            end
        endcase
    end

    // Round-robin pick; the requester granted this cycle is masked so a held req is not granted twice.
    always_comb begin
        req_elig   = req & ~grant;
        cand       = '0;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_addr   = '0;
        rr_ptr_nxt = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (!win_found && req_elig[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_found && (win_idx == PTR_W'(i))) begin
                win_onehot[i] = 1'b1;
                win_addr      = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        if (win_found) begin
            rr_ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            cyc_cnt          <= '0;
            stop_pending     <= 1'b0;
            rr_ptr           <= '0;
            spike_cnt        <= '0;
            grant            <= '0;
            mac_set          <= 1'b0;
            mac_clear        <= 1'b0;
            mac_src_addr     <= '0;
            mac_src_valid    <= 1'b0;
            timestep_count   <= '0;
            last_spike_count <= '0;
            busy             <= 1'b0;
        end else begin
            state         <= state_nxt;
            cyc_cnt       <= cyc_cnt_nxt;
            stop_pending  <= stop_pending_nxt;
            busy          <= (state_nxt != IDLE);
            mac_set       <= (state_nxt == INIT);
            mac_clear     <= (state_nxt == CLEAR);
            grant         <= '0;
            mac_src_valid <= 1'b0;
            mac_src_addr  <= '0;
            if ((state_nxt == RUN) && win_found) begin
                grant         <= win_onehot;
                mac_src_valid <= 1'b1;
                mac_src_addr  <= win_addr;
                rr_ptr        <= rr_ptr_nxt;
                if (spike_cnt != {CNT_W{1'b1}}) begin
                    spike_cnt <= spike_cnt + 1'b1;
                end
            end
            // Timestep bookkeeping happens on the edge entering CLEAR.
            if (state_nxt == CLEAR) begin
                timestep_count   <= timestep_count + 1'b1;
                last_spike_count <= spike_cnt;
                spike_cnt        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mac_spike_scheduler.sv
// Directed bench for mac_spike_scheduler: a scoreboard queue of expected spikes
// checked by a negedge monitor, plus cycle-exact sequencing checks.
module tb_mac_spike_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 12;
    localparam int CNT_W   = 16;

    logic                      CLK = 1'b0;
    logic                      RESET = 1'b1;
    logic                      start = 1'b0;
    logic                      stop = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        grant;
    logic                      mac_set;
    logic                      mac_clear;
    logic [ADDR_W-1:0]         mac_src_addr;
    logic                      mac_src_valid;
    logic [CNT_W-1:0]          timestep_count;
    logic [CNT_W-1:0]          last_spike_count;
    logic                      busy;

    mac_spike_scheduler #(
        .NUM_REQ(4), .ADDR_W(12), .TIMESTEP_CYCLES(4), .INIT_CYCLES(2), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .stop(stop),
        .req(req), .req_addr(req_addr), .grant(grant),
        .mac_set(mac_set), .mac_clear(mac_clear),
        .mac_src_addr(mac_src_addr), .mac_src_valid(mac_src_valid),
        .timestep_count(timestep_count), .last_spike_count(last_spike_count),
        .busy(busy)
    );

    // clock
    always #5 CLK = ~CLK;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_ts = 0;
    bit   mon_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [NUM_REQ-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int idx, input logic [ADDR_W-1:0] a);
        req[idx] = 1'b1;
        req_addr[idx*ADDR_W +: ADDR_W] = a;
    endtask

    // Bounded wait for a grant to requester idx, then release its request.
    task automatic wait_grant(input int idx, input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((grant[idx] !== 1'b1) && (n < limit));
        check("grant_seen", {31'b0, grant[idx]}, 32'd1);
        req[idx] = 1'b0;
    endtask

    // CLEAR cycles fall on cyc % 4 == 2 after a start issued at cyc 0.
    task automatic goto_clear(input int exp_last);
        tick();
        while (cyc % 4 != 2) tick();
        exp_ts++;
        check("clear_pulse", {31'b0, mac_clear}, 32'd1);
        check("clear_busy", {31'b0, busy}, 32'd1);
        check("ts_count", {16'b0, timestep_count}, exp_ts);
        check("last_spikes", {16'b0, last_spike_count}, exp_last);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, {28'b0, grant}, 32'd0);
        check({tag, "_valid"}, {31'b0, mac_src_valid}, 32'd0);
        check({tag, "_addr"}, {20'b0, mac_src_addr}, 32'd0);
        check({tag, "_set"}, {31'b0, mac_set}, 32'd0);
        check({tag, "_clear"}, {31'b0, mac_clear}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_ts"}, {16'b0, timestep_count}, 32'd0);
        check({tag, "_last"}, {16'b0, last_spike_count}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (mon_en) begin
            if (mac_src_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_spike grant=%0h addr=%0h expected=none", grant, mac_src_addr);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("spike", {16'b0, grant, mac_src_addr}, {16'b0, e});
                    check("no_repeat", {28'b0, grant & prev_grant}, 32'd0);
                end
            end else begin
                check("idle_grant", {28'b0, grant}, 32'd0);
            end
            if (mac_clear === 1'b1) check("clear_valid", {31'b0, mac_src_valid}, 32'd0);
            prev_grant = grant;
        end
    end

    initial begin
        // reset
        tick();
        tick();
        check_all_zero("reset");
        RESET = 1'b0;
        mon_en = 1'b1;

        // 1: INIT for 2 cycles, then 3 RUN + 1 CLEAR repeating
        start = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            start = 1'b0;
            if (n >= 6 && (n - 6) % 4 == 0) exp_ts++;
            check("seq_set", {31'b0, mac_set}, (n <= 2) ? 32'd1 : 32'd0);
            check("seq_clear", {31'b0, mac_clear}, (n >= 6 && (n - 6) % 4 == 0) ? 32'd1 : 32'd0);
            check("seq_busy", {31'b0, busy}, 32'd1);
            check("seq_ts", {16'b0, timestep_count}, exp_ts);
        end

        // 2: single requester 2, address 5
        set_req(2, 12'd5);
        exp_q.push_back({4'b0100, 12'd5});
        wait_grant(2, 4);
        goto_clear(1);

        // 3: all four held; rotation continues from pointer 3
        set_req(0, 12'd3);
        set_req(1, 12'd4);
        set_req(2, 12'd5);
        set_req(3, 12'd6);
        exp_q.push_back({4'b1000, 12'd6});
        exp_q.push_back({4'b0001, 12'd3});
        exp_q.push_back({4'b0010, 12'd4});
        exp_q.push_back({4'b0100, 12'd5});
        exp_q.push_back({4'b1000, 12'd6});
        exp_q.push_back({4'b0001, 12'd3});
        exp_q.push_back({4'b0010, 12'd4});
        exp_q.push_back({4'b0100, 12'd5});
        exp_q.push_back({4'b1000, 12'd6});
        for (int t = 0; t < 3; t++) begin
            repeat (3) tick();
            if (t == 2) req = '0;
            goto_clear(3);
        end

        // 4: request first sampled on the edge entering CLEAR
        repeat (3) tick();
        set_req(1, 12'h0AB);
        exp_q.push_back({4'b0010, 12'h0AB});
        goto_clear(0);
        check("clear_no_grant", {28'b0, grant}, 32'd0);
        wait_grant(1, 4);
        goto_clear(1);

        // 5: stop pulse mid-RUN finishes the timestep then idles
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        goto_clear(0);
        tick();
        check("stop_idle_busy", {31'b0, busy}, 32'd0);
        check("stop_idle_clear", {31'b0, mac_clear}, 32'd0);
        check("stop_idle_ts", {16'b0, timestep_count}, exp_ts);
        set_req(0, 12'h007);
        repeat (3) begin
            tick();
            check("idle_busy", {31'b0, busy}, 32'd0);
        end
        req = '0;
        start = 1'b1;
        stop = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("restart_set1", {31'b0, mac_set}, 32'd1);
        check("restart_ts", {16'b0, timestep_count}, exp_ts);
        tick();
        check("restart_set2", {31'b0, mac_set}, 32'd1);
        tick();
        check("restart_set3", {31'b0, mac_set}, 32'd0);
        check("restart_busy", {31'b0, busy}, 32'd1);
        goto_clear(0);

        // 6: reset mid-RUN with a grant active
        set_req(1, 12'h123);
        exp_q.push_back({4'b0010, 12'h123});
        wait_grant(1, 4);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        RESET = 1'b1;
        tick();
        check_all_zero("midreset");
        RESET = 1'b0;
        exp_ts = 0;
        set_req(1, 12'h111);
        set_req(3, 12'h333);
        exp_q.push_back({4'b0010, 12'h111});
        exp_q.push_back({4'b1000, 12'h333});
        start = 1'b1;
        cyc = 0;
        for (int n = 0; n < 10 && req != '0; n++) begin
            tick();
            start = 1'b0;
            if (grant[1] === 1'b1) req[1] = 1'b0;
            if (grant[3] === 1'b1) req[3] = 1'b0;
        end
        check("reqs_served", {28'b0, req}, 32'd0);
        req = '0;
        goto_clear(2);

        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
